// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and
// program memory geometry.
package loader_pkg;
    localparam int PM_DEPTH       = 32;
    localparam int BYTES_PER_WORD = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } loader_state_t;
endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input handshake plus program memory write port, grouped so the
// loader sees one bundle; master = loader side, slave = source/memory side.
interface program_loader_if #(
    parameter int INSTR_WIDTH   = 16,
    parameter int PM_ADDR_WIDTH = 5
);
    logic [7:0]               in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     pm_we;
    logic [PM_ADDR_WIDTH-1:0] pm_addr;
    logic [INSTR_WIDTH-1:0]   pm_wdata;

    modport master (
        input  in_data, in_valid,
        output in_ready, pm_we, pm_addr, pm_wdata
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, pm_we, pm_addr, pm_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Frames a COUNT / data / CHK byte stream into 16-bit instructions, writes them
// to program memory and releases the CPU only after a verified load.
module program_loader
    import loader_pkg::*;
#(
    parameter int INSTR_WIDTH   = 16,
    parameter int PM_ADDR_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    program_loader_if.master    bus,
    output logic                cpu_run,
    output logic                done,
    output logic                error
);
    localparam int CNT_W = PM_ADDR_WIDTH + 1;
    localparam logic [7:0] MAX_N = 8'(PM_DEPTH);

    loader_state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_count, w_count_nxt;
    logic [CNT_W-1:0]         r_words, w_words_nxt;
    logic [PM_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [INSTR_WIDTH-1:0]   r_wdata, w_wdata_nxt;
    logic [7:0]               r_chk, w_chk_nxt;
    logic                     w_in_ready;
    logic                     w_accept;

    assign w_in_ready = (r_state == S_COUNT) || (r_state == S_HI) ||
                        (r_state == S_LO)    || (r_state == S_CHECK);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_words <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_chk   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_words <= w_words_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_chk   <= w_chk_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_words_nxt = r_words;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_chk_nxt   = r_chk;
        // start wins over any byte transferred in the same cycle
        if (start) begin
            w_state_nxt = S_COUNT;
            w_addr_nxt  = '0;
            w_chk_nxt   = '0;
            w_words_nxt = '0;
        end else begin
            unique case (r_state)
                S_IDLE: ;
                S_COUNT: if (w_accept) begin
                    if (bus.in_data == 8'd0) begin
                        w_chk_nxt   = '0;
                        w_state_nxt = S_CHECK;
                    end else if (bus.in_data > MAX_N) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_count_nxt = bus.in_data[CNT_W-1:0];
                        w_words_nxt = '0;
                        w_addr_nxt  = '0;
                        w_chk_nxt   = '0;
                        w_state_nxt = S_HI;
                    end
                end
                S_HI: if (w_accept) begin
                    w_wdata_nxt[INSTR_WIDTH-1 -: 8] = bus.in_data;
                    w_chk_nxt   = r_chk ^ bus.in_data;
                    w_state_nxt = S_LO;
                end
                S_LO: if (w_accept) begin
                    w_wdata_nxt[7:0] = bus.in_data;
                    w_chk_nxt   = r_chk ^ bus.in_data;
                    w_state_nxt = S_WRITE;
                end
                S_WRITE: begin
                    if (r_words + CNT_W'(1) == r_count) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_words_nxt = r_words + CNT_W'(1);
                        w_addr_nxt  = r_addr + PM_ADDR_WIDTH'(1);
                        w_state_nxt = S_HI;
                    end
                end
                S_CHECK: if (w_accept) begin
                    w_state_nxt = (bus.in_data == r_chk) ? S_DONE : S_ERROR;
                end
                S_DONE, S_ERROR: ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.pm_we    = (r_state == S_WRITE);
    assign bus.pm_addr  = r_addr;
    assign bus.pm_wdata = r_wdata;
    assign done         = (r_state == S_DONE);
    assign cpu_run      = (r_state == S_DONE);
    assign error        = (r_state == S_ERROR);
endmodule
